// File: rtl/mem_dsp_vec.sv
// mem_dsp_vec: DEPTH x LANES vector memory with two registered read ports,
// lane-masked write, write-first bypass and a one-vector-per-cycle clear engine.
module mem_dsp_vec #(
    parameter int LANES = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH = 4,
    parameter int INIT_EN = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    input  logic [AW-1:0]     rw,
    input  logic              mem_write,
    input  logic [LANES-1:0]  lane_mask,
    input  logic [DATA_W-1:0] bus_w [LANES-1:0],
    input  logic              clear_req,
    output logic [DATA_W-1:0] bus_a [LANES-1:0],
    output logic [DATA_W-1:0] bus_b [LANES-1:0],
    output logic              busy,
    output logic              wr_drop
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state;
    logic [AW-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH-1:0][LANES-1:0];
    logic [DATA_W-1:0] nxt [DEPTH-1:0][LANES-1:0];

    function automatic logic [DATA_W-1:0] init_val(int v, int i);
        return (INIT_EN != 0 && v < 2) ? DATA_W'((2 * i + 1 + v) << 16) : '0;
    endfunction

    // Post-write array image; reads sample it so both ports see write-first data.
    always_comb
        for (int v = 0; v < DEPTH; v++)
            for (int i = 0; i < LANES; i++)
                nxt[v][i] = (state == CLEAR && ptr == AW'(v)) ? '0 :
                            (state == IDLE && mem_write && lane_mask[i] && rw == AW'(v)) ? bus_w[i] :
                            mem[v][i];

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            busy    <= 1'b0;
            wr_drop <= 1'b0;
            for (int v = 0; v < DEPTH; v++)
                for (int i = 0; i < LANES; i++)
                    mem[v][i] <= init_val(v, i);
            for (int i = 0; i < LANES; i++) begin
                bus_a[i] <= '0;
                bus_b[i] <= '0;
            end
        end else begin
            mem     <= nxt;
            bus_a   <= nxt[ra];
            bus_b   <= nxt[rb];
            wr_drop <= state == CLEAR && mem_write && |lane_mask;
            if (state == IDLE) begin
                if (clear_req) begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            end else begin
                ptr <= ptr + 1'b1;
                if (ptr == AW'(DEPTH - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
endmodule

// File: tb/tb_mem_dsp_vec.sv
// tb_mem_dsp_vec: scoreboard bench for mem_dsp_vec against an array-level reference model.
module tb_mem_dsp_vec;
    localparam int L = 8, W = 32, D = 4, A = 2;

    logic clk = 0, reset = 0;
    logic [A-1:0] ra = '0, rb = '0, rw = '0;
    logic mem_write = 0, clear_req = 0;
    logic [L-1:0] lane_mask = '0;
    logic [W-1:0] bus_w [L-1:0];
    logic [W-1:0] bus_a [L-1:0];
    logic [W-1:0] bus_b [L-1:0];
    logic busy, wr_drop;

    mem_dsp_vec #(.LANES(L), .DATA_W(W), .DEPTH(D), .INIT_EN(1)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rw(rw),
        .mem_write(mem_write), .lane_mask(lane_mask), .bus_w(bus_w),
        .clear_req(clear_req), .bus_a(bus_a), .bus_b(bus_b),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic busy;
        logic drop;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    logic [L*W-1:0] pa, pb;
    logic [W-1:0] m [D][L];
    int clr_left;
    int n_cmp = 0, n_bad = 0;

    task automatic chk(string name, logic [L*W-1:0] act, logic [L*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [L*W-1:0] vec(int v);
        logic [L*W-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = m[v][i];
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < D; v++)
            for (int i = 0; i < L; i++)
                m[v][i] = v == 0 ? W'((2 * i + 1) * 65536) : v == 1 ? W'((2 * i + 2) * 65536) : '0;
        clr_left = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, queue the expected registered outputs.
    task automatic step(bit we, logic [L-1:0] mk, int a_, int b_, int w_, bit clr);
        exp_t e;
        ra = A'(a_); rb = A'(b_); rw = A'(w_);
        mem_write = we; lane_mask = mk; clear_req = clr;
        e.drop = clr_left > 0 && we && mk != 0;
        if (clr_left > 0) begin
            for (int i = 0; i < L; i++) m[D - clr_left][i] = '0;
            clr_left--;
        end else begin
            if (we)
                for (int i = 0; i < L; i++) if (mk[i]) m[w_][i] = bus_w[i];
            if (clr) clr_left = D;
        end
        e.busy = clr_left > 0;
        e.a = vec(a_);
        e.b = vec(b_);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic rand_data();
        for (int i = 0; i < L; i++) bus_w[i] = $urandom;
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            for (int i = 0; i < L; i++) begin
                pa[i*W +: W] = bus_a[i];
                pb[i*W +: W] = bus_b[i];
            end
            chk("bus_a", pa, e_mon.a);
            chk("bus_b", pb, e_mon.b);
            chk("busy", {{(L*W-1){1'b0}}, busy}, {{(L*W-1){1'b0}}, e_mon.busy});
            chk("wr_drop", {{(L*W-1){1'b0}}, wr_drop}, {{(L*W-1){1'b0}}, e_mon.drop});
        end

    initial begin
        for (int i = 0; i < L; i++) bus_w[i] = '0;
        model_reset();
        rb = 1;
        #12 reset = 1;
        // init pattern visible after reset release
        step(0, '0, 0, 1, 0, 0);
        // masked write with same-cycle bypass read, then re-read
        for (int i = 0; i < L; i++) bus_w[i] = W'(32'hA0 + i);
        step(1, 8'h0F, 2, 2, 2, 0);
        step(0, '0, 2, 0, 0, 0);
        // clear with a re-request at busy cycle 2, reading each vector as it goes
        step(0, '0, 0, 1, 0, 1);
        step(0, '0, 1, 2, 0, 0);
        step(0, '0, 2, 3, 0, 1);
        step(0, '0, 3, 0, 0, 0);
        step(0, '0, 3, 2, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 2, 3, 0, 0);
        // write during busy is dropped
        step(0, '0, 0, 0, 0, 1);
        rand_data();
        step(1, 8'hFF, 1, 1, 1, 0);
        step(1, 8'h00, 1, 0, 1, 0);
        step(0, '0, 1, 1, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 1, 0, 0);
        // write + clear together
        rand_data();
        step(1, 8'hFF, 3, 3, 3, 1);
        for (int k = 0; k < 5; k++) step(0, '0, 3, k % D, 0, 0);
        // reset mid-clear
        rand_data();
        step(1, 8'h3C, 2, 2, 2, 0);
        step(0, '0, 2, 0, 0, 1);
        step(0, '0, 2, 1, 0, 0);
        @(negedge clk);
        #1 reset = 0;
        #1;
        pa = '0;
        for (int i = 0; i < L; i++) pa[i*W +: W] = bus_a[i];
        chk("busy_async_reset", {{(L*W-1){1'b0}}, busy}, '0);
        chk("bus_a_async_reset", pa, '0);
        model_reset();
        @(negedge clk);
        reset = 1;
        step(0, '0, 0, 2, 0, 0);
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            rand_data();
            step($urandom_range(1, 0) == 1, ($urandom_range(7, 0) == 0) ? L'(0) : L'($urandom),
                 $urandom_range(D - 1, 0), $urandom_range(D - 1, 0), $urandom_range(D - 1, 0),
                 $urandom_range(11, 0) == 0);
        end
        mem_write = 0;
        clear_req = 0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_dsp_vec.md
Name: mem_dsp_vec

Overview:
Parametrised successor to the DSP vector memory: DEPTH vectors of LANES elements, each DATA_W bits wide.
- Two registered vector read ports and one vector write port with per-lane write mask.
- Write-first read bypass.
- Sequential clear engine that zeroes the array one vector per cycle.
- Sits beside the vector register file in CPU_DSP and feeds the DSP datapath operands.

Parameters:
LANES, 8, elements per vector
DATA_W, 32, bits per element
DEPTH, 4, vectors stored (power of two, >=2)
INIT_EN, 1, 1 = load the fixed init pattern on reset; 0 = all zeros
AW, $clog2(DEPTH), vector address width (derived; not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ra  in  AW  read port A vector address
rb  in  AW  read port B vector address
rw  in  AW  write vector address
mem_write  in  1  write enable
lane_mask  in  LANES  per-lane write enable; bit i gates bus_w[i]
bus_w  in  LANES x DATA_W  write vector, unpacked [LANES-1:0]
clear_req  in  1  request a full-array clear
bus_a  out  LANES x DATA_W  registered read data, port A
bus_b  out  LANES x DATA_W  registered read data, port B
busy  out  1  clear engine active
wr_drop  out  1  one-cycle pulse: a write was rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - bus_a, bus_b, busy and wr_drop go to 0; FSM goes to IDLE.
  - If INIT_EN=1: vector 0 lane i = (2i+1)<<16, vector 1 lane i = (2i+2)<<16, all other vectors 0 (LANES=8, DATA_W=32: 0x00010000, 0x00030000 .. 0x000F0000 / 0x00020000 .. 0x00100000).
  - If INIT_EN=0: all vectors 0.
  - Reset mid-clear aborts the clear and reloads the init pattern.
- Read:
  - 1-cycle latency. bus_a on edge N+1 reflects vector ra sampled at edge N.
  - Write-first: if a write (user or clear) targets the same vector at edge N, the read returns the post-write contents, lane by lane. Masked-off lanes return the old value.
  - ra == rb is legal; both ports return identical data.
- Write, FSM in IDLE:
  - At the edge with mem_write=1, lanes with lane_mask[i]=1 take bus_w[i]; other lanes are unchanged.
  - lane_mask all zeros is a no-op and does not assert wr_drop.
- Clear FSM, states IDLE and CLEAR, counter ptr of AW bits:
  - IDLE -> CLEAR: on clear_req=1 at an edge. ptr <= 0, busy <= 1.
  - CLEAR: each edge writes zeros to all lanes of vector ptr, then ptr <= ptr+1.
  - CLEAR -> IDLE: at the edge where ptr == DEPTH-1 is cleared; busy <= 0 at that edge.
  - busy is high for exactly DEPTH cycles.
  - clear_req while in CLEAR is ignored; it does not restart or extend the clear.
- Simultaneous events:
  - mem_write and clear_req together in IDLE: the write commits this edge and the clear starts next cycle, so the written data is subsequently cleared.
  - mem_write=1 with a nonzero mask while busy=1: the write is dropped and wr_drop=1 on the following cycle.
  - Reads remain serviced during CLEAR, with bypass applying to the vector being cleared.
- Address width is exact; there is no wrap arithmetic on addresses. ptr wraps to 0 only at CLEAR exit.

Test Plan:
1. Reset release with INIT_EN=1, ra=0, rb=1 -> one cycle later bus_a[7]=0x000F0000, bus_b[0]=0x00020000, busy=0, wr_drop=0.
2. Write rw=2, lane_mask=0x0F, bus_w[i]=0xA0+i, with ra=2 in the same cycle -> next cycle bus_a[0..3]=0xA0..0xA3 (bypass) and bus_a[4..7]=0. Re-read of vector 2 returns the same.
3. Pulse clear_req -> busy high for exactly 4 cycles. Afterwards vectors 0..3 read all zeros. A second clear_req at busy cycle 2 does not extend busy.
4. mem_write=1, mask=0xFF during busy -> wr_drop pulses 1 cycle later and the target vector is zero after the clear completes.
5. mem_write to rw=3 together with clear_req in IDLE -> vector 3 reads the written data during the first 3 busy cycles and zero after ptr=3 is cleared.
6. Assert reset at busy cycle 2 -> busy=0 immediately; after release vector 0 lane 0 = 0x00010000 and vector 2 = 0.
